// File: rtl/npc_stage_sequencer.sv
// Multi-cycle control sequencer for the npc datapath: IF -> ID -> EX -> [MEM] -> WB.
// Issues single-cycle commit strobes, memory handshakes with a wait watchdog, and perf counters.
module npc_stage_sequencer #(
  parameter int unsigned CNT_W    = 64,
  parameter int unsigned WAIT_W   = 8,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifu_rvalid,
  input  logic             lsu_done,
  input  logic             en_Wreg,
  input  logic             en_Wmem,
  input  logic             load,
  input  logic             branch,
  input  logic             ebreak,
  output logic             ifu_req,
  output logic             ir_we,
  output logic             lsu_req,
  output logic             lsu_wen,
  output logic             reg_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t            st;
  logic [WAIT_W-1:0] wait_cnt;

  // Sequencing, watchdog and counters; a timeout or corrupt encoding halts with fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_IF;
      wait_cnt    <= '0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      if (st != S_HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
      case (st)
        S_IF: begin
          if (ifu_rvalid) begin
            st       <= S_ID;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
            st     <= S_HALT;
            halted <= 1'b1;
            fault  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_ID: begin
          if (ebreak) begin
            st     <= S_HALT;
            halted <= 1'b1;
          end else begin
            st <= S_EX;
          end
        end
        S_EX: st <= (load | en_Wmem) ? S_MEM : S_WB;
        S_MEM: begin
          if (lsu_done) begin
            st       <= S_WB;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
            st     <= S_HALT;
            halted <= 1'b1;
            fault  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WB: begin
          st          <= S_IF;
          instret_cnt <= instret_cnt + CNT_W'(1);
        end
        S_HALT: st <= S_HALT;
        default: begin
          st     <= S_HALT;
          halted <= 1'b1;
          fault  <= 1'b1;
        end
      endcase
    end
  end

  // State decodes; masked by rst so a reset cycle never commits or requests.
  assign state   = st;
  assign ifu_req = ~rst & (st == S_IF);
  assign ir_we   = ~rst & (st == S_IF) & ifu_rvalid;
  assign lsu_req = ~rst & (st == S_MEM);
  assign lsu_wen = ~rst & (st == S_MEM) & en_Wmem;
  assign pc_we   = ~rst & (st == S_WB);
  assign pc_sel  = ~rst & (st == S_WB) & branch;
  assign reg_we  = ~rst & (st == S_WB) & en_Wreg & ~en_Wmem;

endmodule

// File: tb/tb_npc_stage_sequencer.sv
// Directed bench for npc_stage_sequencer: ALU, branch, load, store, timeout, ebreak and reset-abort.
module tb_npc_stage_sequencer;

  logic        clk, rst;
  logic        ifu_rvalid, lsu_done, en_Wreg, en_Wmem, load, branch, ebreak;
  logic        ifu_req, ir_we, lsu_req, lsu_wen, reg_we, pc_we, pc_sel, halted, fault;
  logic [2:0]  state;
  logic [63:0] cycle_cnt, instret_cnt;

  int checks = 0;
  int failures = 0;
  int n_req, n_wen, n_rwe, n_pwe, n_irwe;

  npc_stage_sequencer #(.CNT_W(64), .WAIT_W(8), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .ifu_rvalid(ifu_rvalid), .lsu_done(lsu_done),
    .en_Wreg(en_Wreg), .en_Wmem(en_Wmem), .load(load), .branch(branch), .ebreak(ebreak),
    .ifu_req(ifu_req), .ir_we(ir_we), .lsu_req(lsu_req), .lsu_wen(lsu_wen),
    .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel), .state(state),
    .halted(halted), .fault(fault), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    ifu_rvalid = 1'b0; lsu_done = 1'b0; en_Wreg = 1'b0; en_Wmem = 1'b0;
    load = 1'b0; branch = 1'b0; ebreak = 1'b0;
  endtask

  task automatic clear_counts;
    n_req = 0; n_wen = 0; n_rwe = 0; n_pwe = 0; n_irwe = 0;
  endtask

  // One reset cycle with responses present; they must be ignored.
  task automatic do_reset;
    rst = 1'b1; ifu_rvalid = 1'b1; lsu_done = 1'b1;
    #1;
    chk("rst_ir_we", 64'(ir_we), 64'd0);
    next_cycle();
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    do_reset();
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_cycle", cycle_cnt, 64'd0);
    chk("rst_instret", instret_cnt, 64'd0);

    // ADD x2: IF ID EX WB IF ID EX WB
    ifu_rvalid = 1'b1; en_Wreg = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("add_state", 64'(state), (c % 4 == 3) ? 64'd4 : 64'(c % 4));
      chk("add_reg_we", 64'(reg_we), 64'(c % 4 == 3));
      chk("add_pc_we", 64'(pc_we), 64'(c % 4 == 3));
      chk("add_ir_we", 64'(ir_we), 64'(c % 4 == 0));
      if (c % 4 == 3) chk("add_pc_sel", 64'(pc_sel), 64'd0);
      next_cycle();
    end
    #1;
    chk("add_instret", instret_cnt, 64'd2);
    chk("add_cycle", cycle_cnt, 64'd8);

    // Branch: pc_sel follows branch in WB
    do_reset();
    ifu_rvalid = 1'b1; en_Wreg = 1'b1; branch = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (c == 3) begin
        chk("br_pc_we", 64'(pc_we), 64'd1);
        chk("br_pc_sel", 64'(pc_sel), 64'd1);
        chk("br_reg_we", 64'(reg_we), 64'd1);
      end
      next_cycle();
    end

    // Load with lsu_done on the third MEM cycle: latency 7
    do_reset();
    clear_counts();
    ifu_rvalid = 1'b1; load = 1'b1; en_Wreg = 1'b1;
    for (int c = 0; c < 7; c++) begin
      lsu_done = (c == 5);
      #1;
      n_req += int'(lsu_req); n_wen += int'(lsu_wen);
      n_rwe += int'(reg_we);  n_pwe += int'(pc_we);
      if (c == 6) chk("ld_wb_state", 64'(state), 64'd4);
      next_cycle();
    end
    #1;
    chk("ld_lsu_req_cycles", 64'(n_req), 64'd3);
    chk("ld_lsu_wen_cycles", 64'(n_wen), 64'd0);
    chk("ld_reg_we_cycles", 64'(n_rwe), 64'd1);
    chk("ld_pc_we_cycles", 64'(n_pwe), 64'd1);
    chk("ld_state", 64'(state), 64'd0);
    chk("ld_instret", instret_cnt, 64'd1);
    chk("ld_cycle", cycle_cnt, 64'd7);

    // Store with zero-wait memory: 5 cycles, no rd write
    do_reset();
    clear_counts();
    ifu_rvalid = 1'b1; en_Wmem = 1'b1; en_Wreg = 1'b1; lsu_done = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_req += int'(lsu_req); n_wen += int'(lsu_wen);
      n_rwe += int'(reg_we);  n_pwe += int'(pc_we);
      if (c == 4) chk("st_pc_sel", 64'(pc_sel), 64'd0);
      next_cycle();
    end
    #1;
    chk("st_lsu_req_cycles", 64'(n_req), 64'd1);
    chk("st_lsu_wen_cycles", 64'(n_wen), 64'd1);
    chk("st_reg_we_cycles", 64'(n_rwe), 64'd0);
    chk("st_pc_we_cycles", 64'(n_pwe), 64'd1);
    chk("st_instret", instret_cnt, 64'd1);
    chk("st_cycle", cycle_cnt, 64'd5);

    // Fetch timeout: 5 unanswered IF cycles then fault halt
    do_reset();
    clear_counts();
    for (int c = 0; c < 5; c++) begin
      #1;
      n_req += int'(ifu_req);
      next_cycle();
    end
    #1;
    chk("to_ifu_req_cycles", 64'(n_req), 64'd5);
    chk("to_state", 64'(state), 64'd5);
    chk("to_halted", 64'(halted), 64'd1);
    chk("to_fault", 64'(fault), 64'd1);
    chk("to_cycle", cycle_cnt, 64'd5);
    ifu_rvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("to_halt_ifu_req", 64'(ifu_req), 64'd0);
      chk("to_halt_ir_we", 64'(ir_we), 64'd0);
      next_cycle();
    end
    #1;
    chk("to_frozen_state", 64'(state), 64'd5);
    chk("to_frozen_cycle", cycle_cnt, 64'd5);
    chk("to_frozen_instret", instret_cnt, 64'd0);

    // Response in the timeout cycle wins
    do_reset();
    for (int c = 0; c < 5; c++) begin
      ifu_rvalid = (c == 4);
      #1;
      if (c == 4) chk("tw_ir_we", 64'(ir_we), 64'd1);
      next_cycle();
    end
    #1;
    chk("tw_state", 64'(state), 64'd1);
    chk("tw_fault", 64'(fault), 64'd0);
    chk("tw_halted", 64'(halted), 64'd0);

    // Ebreak: clean halt, no PC update
    do_reset();
    clear_counts();
    ifu_rvalid = 1'b1; ebreak = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_pwe += int'(pc_we);
      next_cycle();
    end
    #1;
    chk("eb_state", 64'(state), 64'd5);
    chk("eb_halted", 64'(halted), 64'd1);
    chk("eb_fault", 64'(fault), 64'd0);
    chk("eb_pc_we_cycles", 64'(n_pwe), 64'd0);
    chk("eb_cycle", cycle_cnt, 64'd2);
    do_reset();
    #1;
    chk("eb_rst_state", 64'(state), 64'd0);
    chk("eb_rst_halted", 64'(halted), 64'd0);
    chk("eb_rst_cycle", cycle_cnt, 64'd0);

    // Reset in MEM with lsu_done the same cycle aborts the load
    do_reset();
    ifu_rvalid = 1'b1; load = 1'b1; en_Wreg = 1'b1;
    for (int c = 0; c < 3; c++) next_cycle();
    #1;
    chk("ra_mem_state", 64'(state), 64'd3);
    rst = 1'b1; lsu_done = 1'b1;
    #1;
    chk("ra_reg_we", 64'(reg_we), 64'd0);
    chk("ra_pc_we", 64'(pc_we), 64'd0);
    chk("ra_lsu_req", 64'(lsu_req), 64'd0);
    next_cycle();
    rst = 1'b0; lsu_done = 1'b0; ifu_rvalid = 1'b0;
    #1;
    chk("ra_state", 64'(state), 64'd0);
    chk("ra_instret", instret_cnt, 64'd0);
    chk("ra_reg_we_after", 64'(reg_we), 64'd0);
    chk("ra_pc_we_after", 64'(pc_we), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
